terminate_issue_queue: RTL and testbench
========================================

# terminate_issue_queue

Issue queue and scheduler in front of the terminate (jump/branch) pipeline. Holds up to DEPTH renamed jump/branch micro-ops, tracks readiness of each op's base-register and flag-register physical tags via wakeup broadcasts, and issues the oldest ready op into a registered output stage using a valid/ready handshake. It sits between rename/dispatch and the terminate pipeline. It forwards tags, not data: the register-file read happens downstream.

## Interface
- DEPTH, 4, number of queue entries (2..8)
- PTAG_W, 5, physical register tag width
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all queued and staged ops
- in_valid  input  1  dispatch offers an op
- in_ready  output  1  queue accepts the op (count < DEPTH)
- in_opcode  input  4  opcode
- in_offset  input  8  relative offset
- in_immediate  input  4  immediate / flag selector
- in_ROB_entry  input  5  ROB index
- in_arch_dest_regs  input  8  architectural destinations
- in_phys_dest_regs  input  10  physical destinations
- in_base_tag, in_flag_tag  input  PTAG_W each  source tags
- in_base_rdy, in_flag_rdy  input  1 each  source already available at dispatch
- wake_valid  input  2  per-port wakeup strobe
- wake_tags  input  2*PTAG_W  port 0 in [PTAG_W-1:0], port 1 above it
- out_valid  output  1  staged op valid
- out_ready  input  1  terminate pipeline accepts
- out_opcode, out_offset, out_immediate, out_ROB_entry, out_arch_dest_regs, out_phys_dest_regs, out_base_tag, out_flag_tag  output  matching widths  staged op fields
- count  output  $clog2(DEPTH+1)  occupied entries, excluding the output stage

## Operation
- Storage is a collapsing queue. Entry 0 is the oldest. Each entry holds a valid bit, all op fields, base_rdy and flag_rdy.
- Enqueue fires when in_valid & in_ready. The op is written at slot count, or at slot count-1 if an issue occurs in the same cycle.
  - in_ready depends only on the registered count. Same-cycle issue gives no credit.
- Captured ready bit = in_*_rdy OR a same-cycle match of the tag on either valid wake port.
- Wakeup: every valid entry whose base_tag or flag_tag equals a valid wake tag sets the matching rdy bit at the next edge. The bit is sticky until the entry leaves.
- Selection uses registered rdy bits only. The candidate is the lowest index entry with valid & base_rdy & flag_rdy.
- Issue fires when a candidate exists AND (!out_valid | out_ready). The candidate moves into the output register. Entries above it shift down one slot, and their pending wake captures apply to the shifted position.
- Output register: loaded on issue. out_valid clears on out_ready when nothing new is loaded. Fields hold steady while out_valid & !out_ready.
- flush has priority over everything. At the next edge all entries become invalid, out_valid=0 and count=0. A same-cycle enqueue is dropped.
- Tags equal in base and flag, or matched on both ports, set the bit once. This is not an error.

## Timing
- Reset values: out_valid=0, count=0, all entries invalid. in_ready=1 after reset. All out_* data fields are 0.
- Without the bypass, minimum latency is 2 cycles. An op enqueued ready at edge N is selectable in cycle N, and out_valid is asserted after edge N+1.
- Wakeup to issue: a wake in cycle N sets rdy at edge N+1. The op is staged at edge N+2.
- Throughput is one issue per cycle while out_ready=1.
- Full: count=DEPTH forces in_ready=0, even if an issue happens that cycle.
- Reset asserted mid-operation clears state immediately (asynchronous). It is released synchronously with respect to the next clk edge by the top level.

## Configuration
- TERM_IQ_BYPASS_EN defined: when count=0 and the incoming op is ready (after same-cycle wake capture) and (!out_valid | out_ready), the op is written directly into the output register. out_valid is asserted after that same edge, giving 1-cycle latency, and count is unchanged.
- TERM_IQ_BYPASS_EN undefined: every op passes through the queue, and the minimum latency is 2 cycles.

## Test plan
- Reset then idle: out_valid=0, count=0, in_ready=1. Enqueue a ready op (ROB=5, offset=0x10) with out_ready=1. The op appears on out_* 2 cycles later, or 1 cycle later with the bypass enabled.
- Enqueue A (base_tag=3, not ready), then B (ready). B issues first. Wake tag 3 in cycle N, and A stages at edge N+2.
- Fill 4 entries with out_ready=0: count=4 and in_ready=0. Raise out_ready: one issue per cycle, and in_ready=1 one cycle after the first issue.
- Same-cycle enqueue (tag 7, not ready) with wake_valid[1]=1 and wake_tags[9:5]=7: the op is captured ready and issues with no further wake.
- Hold out_ready=0 with out_valid=1 for 3 cycles: out_* is stable. Then assert flush together with in_valid: out_valid=0 and count=0 next cycle, and the new op is not stored.
- Assert rst asynchronously while count=3: count=0 and out_valid=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/terminate_issue_queue.sv
// +---------------------------------------------------------------------------+
// | terminate_issue_queue                                                     |
// | Collapsing issue queue + registered output stage for jump/branch uops.    |
// | Optional: TERM_IQ_BYPASS_EN (empty-queue bypass into the output stage).   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module terminate_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int PTAG_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_opcode,
  input  logic [7:0]                   in_offset,
  input  logic [3:0]                   in_immediate,
  input  logic [4:0]                   in_ROB_entry,
  input  logic [7:0]                   in_arch_dest_regs,
  input  logic [9:0]                   in_phys_dest_regs,
  input  logic [PTAG_W-1:0]            in_base_tag,
  input  logic [PTAG_W-1:0]            in_flag_tag,
  input  logic                         in_base_rdy,
  input  logic                         in_flag_rdy,
  input  logic [1:0]                   wake_valid,
  input  logic [2*PTAG_W-1:0]          wake_tags,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_opcode,
  output logic [7:0]                   out_offset,
  output logic [3:0]                   out_immediate,
  output logic [4:0]                   out_ROB_entry,
  output logic [7:0]                   out_arch_dest_regs,
  output logic [9:0]                   out_phys_dest_regs,
  output logic [PTAG_W-1:0]            out_base_tag,
  output logic [PTAG_W-1:0]            out_flag_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_PAY_W = 39;

  logic [c_PAY_W-1:0] r_pay      [DEPTH];
  logic [PTAG_W-1:0]  r_base_tag [DEPTH];
  logic [PTAG_W-1:0]  r_flag_tag [DEPTH];
  logic [DEPTH-1:0]   r_valid, r_base_rdy, r_flag_rdy;
  logic [c_CNT_W-1:0] r_count;
  logic               r_out_valid;
  logic [c_PAY_W-1:0] r_out_pay;
  logic [PTAG_W-1:0]  r_out_base_tag, r_out_flag_tag;

  // Entry view after wakeup, padded with an empty slot so the shift needs no bound check.
  logic [c_PAY_W-1:0] w_ext_pay      [DEPTH+1];
  logic [PTAG_W-1:0]  w_ext_base_tag [DEPTH+1];
  logic [PTAG_W-1:0]  w_ext_flag_tag [DEPTH+1];
  logic [DEPTH:0]     w_ext_valid, w_ext_base_rdy, w_ext_flag_rdy;

  logic [c_PAY_W-1:0] w_nxt_pay      [DEPTH];
  logic [PTAG_W-1:0]  w_nxt_base_tag [DEPTH];
  logic [PTAG_W-1:0]  w_nxt_flag_tag [DEPTH];
  logic [DEPTH-1:0]   w_nxt_valid, w_nxt_base_rdy, w_nxt_flag_rdy;

  logic [c_PAY_W-1:0] w_in_pay;
  logic               w_in_base_rdy, w_in_flag_rdy;
  logic               w_has_cand, w_out_free, w_issue, w_enq, w_enq_q, w_bypass;
  logic [c_IDX_W-1:0] w_sel;
  logic [c_CNT_W-1:0] w_enq_idx;

  function automatic logic wake_hit(input logic [PTAG_W-1:0] tag);
    return (wake_valid[0] && (wake_tags[PTAG_W-1:0] == tag)) ||
           (wake_valid[1] && (wake_tags[2*PTAG_W-1:PTAG_W] == tag));
  endfunction

  assign w_in_pay      = {in_opcode, in_offset, in_immediate, in_ROB_entry,
                          in_arch_dest_regs, in_phys_dest_regs};
  assign w_in_base_rdy = in_base_rdy | wake_hit(in_base_tag);
  assign w_in_flag_rdy = in_flag_rdy | wake_hit(in_flag_tag);

  assign in_ready   = (r_count != c_CNT_W'(DEPTH));
  assign w_out_free = !r_out_valid || out_ready;
  assign w_enq      = in_valid && in_ready;

`ifdef TERM_IQ_BYPASS_EN
  // An empty queue has no candidate, so bypass never collides with an issue.
  assign w_bypass = w_enq && (r_count == '0) && w_in_base_rdy && w_in_flag_rdy && w_out_free;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_enq_q   = w_enq && !w_bypass;
  assign w_issue   = w_has_cand && w_out_free;
  assign w_enq_idx = r_count - c_CNT_W'(w_issue);

  always_comb begin
    w_has_cand = 1'b0;
    w_sel      = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (r_valid[i] && r_base_rdy[i] && r_flag_rdy[i]) begin
        w_has_cand = 1'b1;
        w_sel      = c_IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ext_valid[i]    = r_valid[i];
      w_ext_pay[i]      = r_pay[i];
      w_ext_base_tag[i] = r_base_tag[i];
      w_ext_flag_tag[i] = r_flag_tag[i];
      w_ext_base_rdy[i] = r_base_rdy[i] | (r_valid[i] & wake_hit(r_base_tag[i]));
      w_ext_flag_rdy[i] = r_flag_rdy[i] | (r_valid[i] & wake_hit(r_flag_tag[i]));
    end
    w_ext_valid[DEPTH]    = 1'b0;
    w_ext_pay[DEPTH]      = '0;
    w_ext_base_tag[DEPTH] = '0;
    w_ext_flag_tag[DEPTH] = '0;
    w_ext_base_rdy[DEPTH] = 1'b0;
    w_ext_flag_rdy[DEPTH] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_issue && (i >= int'(w_sel))) begin
        w_nxt_valid[i]    = w_ext_valid[i+1];
        w_nxt_pay[i]      = w_ext_pay[i+1];
        w_nxt_base_tag[i] = w_ext_base_tag[i+1];
        w_nxt_flag_tag[i] = w_ext_flag_tag[i+1];
        w_nxt_base_rdy[i] = w_ext_base_rdy[i+1];
        w_nxt_flag_rdy[i] = w_ext_flag_rdy[i+1];
      end else begin
        w_nxt_valid[i]    = w_ext_valid[i];
        w_nxt_pay[i]      = w_ext_pay[i];
        w_nxt_base_tag[i] = w_ext_base_tag[i];
        w_nxt_flag_tag[i] = w_ext_flag_tag[i];
        w_nxt_base_rdy[i] = w_ext_base_rdy[i];
        w_nxt_flag_rdy[i] = w_ext_flag_rdy[i];
      end
      if (w_enq_q && (w_enq_idx == c_CNT_W'(i))) begin
        w_nxt_valid[i]    = 1'b1;
        w_nxt_pay[i]      = w_in_pay;
        w_nxt_base_tag[i] = in_base_tag;
        w_nxt_flag_tag[i] = in_flag_tag;
        w_nxt_base_rdy[i] = w_in_base_rdy;
        w_nxt_flag_rdy[i] = w_in_flag_rdy;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_base_rdy <= '0;
      r_flag_rdy <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pay[i]      <= '0;
        r_base_tag[i] <= '0;
        r_flag_tag[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid    <= w_nxt_valid;
      r_base_rdy <= w_nxt_base_rdy;
      r_flag_rdy <= w_nxt_flag_rdy;
      r_count    <= r_count + c_CNT_W'(w_enq_q) - c_CNT_W'(w_issue);
      for (int i = 0; i < DEPTH; i++) begin
        r_pay[i]      <= w_nxt_pay[i];
        r_base_tag[i] <= w_nxt_base_tag[i];
        r_flag_tag[i] <= w_nxt_flag_tag[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_pay      <= '0;
      r_out_base_tag <= '0;
      r_out_flag_tag <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_issue) begin
      r_out_valid    <= 1'b1;
      r_out_pay      <= r_pay[w_sel];
      r_out_base_tag <= r_base_tag[w_sel];
      r_out_flag_tag <= r_flag_tag[w_sel];
    end else if (w_bypass) begin
      r_out_valid    <= 1'b1;
      r_out_pay      <= w_in_pay;
      r_out_base_tag <= in_base_tag;
      r_out_flag_tag <= in_flag_tag;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_base_tag = r_out_base_tag;
  assign out_flag_tag = r_out_flag_tag;
  assign count        = r_count;
  assign {out_opcode, out_offset, out_immediate, out_ROB_entry,
          out_arch_dest_regs, out_phys_dest_regs} = r_out_pay;

endmodule

`default_nettype wire

// File: tb/tb_terminate_issue_queue.sv
// +---------------------------------------------------------------------------+
// | tb_terminate_issue_queue                                                  |
// | Directed scoreboard bench for terminate_issue_queue (DEPTH=4, PTAG_W=5).  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_terminate_issue_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [7:0]  in_offset = '0;
  logic [3:0]  in_immediate = '0;
  logic [4:0]  in_ROB_entry = '0;
  logic [7:0]  in_arch_dest_regs = '0;
  logic [9:0]  in_phys_dest_regs = '0;
  logic [4:0]  in_base_tag = '0, in_flag_tag = '0;
  logic        in_base_rdy = 1'b0, in_flag_rdy = 1'b0;
  logic [1:0]  wake_valid = '0;
  logic [9:0]  wake_tags = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_opcode;
  logic [7:0]  out_offset;
  logic [3:0]  out_immediate;
  logic [4:0]  out_ROB_entry;
  logic [7:0]  out_arch_dest_regs;
  logic [9:0]  out_phys_dest_regs;
  logic [4:0]  out_base_tag, out_flag_tag;
  logic [2:0]  count;

  terminate_issue_queue #(.DEPTH(4), .PTAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_offset(in_offset), .in_immediate(in_immediate),
    .in_ROB_entry(in_ROB_entry), .in_arch_dest_regs(in_arch_dest_regs),
    .in_phys_dest_regs(in_phys_dest_regs),
    .in_base_tag(in_base_tag), .in_flag_tag(in_flag_tag),
    .in_base_rdy(in_base_rdy), .in_flag_rdy(in_flag_rdy),
    .wake_valid(wake_valid), .wake_tags(wake_tags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_offset(out_offset), .out_immediate(out_immediate),
    .out_ROB_entry(out_ROB_entry), .out_arch_dest_regs(out_arch_dest_regs),
    .out_phys_dest_regs(out_phys_dest_regs),
    .out_base_tag(out_base_tag), .out_flag_tag(out_flag_tag),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef logic [48:0] exp_t;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Side fields are fixed functions of the ROB index so every op is distinguishable.
  function automatic exp_t mk(input logic [4:0] rob, input logic [7:0] off,
                              input logic [3:0] opc, input logic [4:0] bt,
                              input logic [4:0] ft);
    return {rob, off, opc, rob[3:0] ^ 4'hA, {3'b000, rob}, {rob, rob}, bt, ft};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [4:0] rob, input logic [7:0] off, input logic [3:0] opc,
                     input logic [4:0] bt, input logic br, input logic [4:0] ft,
                     input logic fr);
    in_valid          = 1'b1;
    in_ROB_entry      = rob;
    in_offset         = off;
    in_opcode         = opc;
    in_immediate      = rob[3:0] ^ 4'hA;
    in_arch_dest_regs = {3'b000, rob};
    in_phys_dest_regs = {rob, rob};
    in_base_tag       = bt;
    in_base_rdy       = br;
    in_flag_tag       = ft;
    in_flag_rdy       = fr;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_base_rdy = 1'b0;
    in_flag_rdy = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest expected op.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got rob %0d, expected no output", out_ROB_entry);
      end else begin
        exp_t e;
        exp_t a;
        e = sb.pop_front();
        a = {out_ROB_entry, out_offset, out_opcode, out_immediate, out_arch_dest_regs,
             out_phys_dest_regs, out_base_tag, out_flag_tag};
        if (a !== e) begin
          n_bad++;
          $display("FAIL out_op: got 0x%0h, expected 0x%0h", a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_rob", out_ROB_entry, 0);
    chk("rst_out_offset", out_offset, 0);

    // Single ready op latency
    out_ready = 1'b1;
    enq(5'd5, 8'h10, 4'h2, 5'd1, 1'b1, 5'd2, 1'b1);
    sb.push_back(mk(5'd5, 8'h10, 4'h2, 5'd1, 5'd2));
    tick(); idle();
`ifdef TERM_IQ_BYPASS_EN
    chk("lat_valid_n", out_valid, 1);
    chk("lat_count_n", count, 0);
`else
    chk("lat_valid_n", out_valid, 0);
    chk("lat_count_n", count, 1);
    tick();
    chk("lat_valid_n1", out_valid, 1);
    chk("lat_rob_n1", out_ROB_entry, 5);
`endif
    tick();
    chk("lat_drain", out_valid, 0);

    // Younger ready op overtakes older waiting op; wake then stage at N+2
    enq(5'd6, 8'h21, 4'h3, 5'd3, 1'b0, 5'd21, 1'b1);
    tick();
    enq(5'd7, 8'h22, 4'h4, 5'd4, 1'b1, 5'd22, 1'b1);
    sb.push_back(mk(5'd7, 8'h22, 4'h4, 5'd4, 5'd22));
    sb.push_back(mk(5'd6, 8'h21, 4'h3, 5'd3, 5'd21));
    tick(); idle();
    tick();
    chk("ooo_b_valid", out_valid, 1);
    chk("ooo_b_rob", out_ROB_entry, 7);
    wake_valid = 2'b01;
    wake_tags  = {5'd0, 5'd3};
    tick();
    wake_valid = 2'b00;
    chk("wake_n1_valid", out_valid, 0);
    chk("wake_n1_count", count, 1);
    tick();
    chk("wake_n2_valid", out_valid, 1);
    chk("wake_n2_rob", out_ROB_entry, 6);
    chk("wake_n2_count", count, 0);
    tick();

    // Fill with output stalled; first op lands in the output stage
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      enq(5'(10 + k), 8'(8'h40 + k), 4'(k), 5'(8 + k), 1'b1, 5'(16 + k), 1'b1);
      sb.push_back(mk(5'(10 + k), 8'(8'h40 + k), 4'(k), 5'(8 + k), 5'(16 + k)));
      tick();
    end
    enq(5'd15, 8'h4F, 4'hF, 5'd13, 1'b1, 5'd14, 1'b1);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_rob", out_ROB_entry, 10);
    out_ready = 1'b1;
    tick(); idle();
    chk("drain_count3", count, 3);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_rob11", out_ROB_entry, 11);
    tick();
    chk("drain_count2", count, 2);
    chk("drain_rob12", out_ROB_entry, 12);
    tick();
    chk("drain_count1", count, 1);
    tick();
    chk("drain_count0", count, 0);
    chk("drain_rob14", out_ROB_entry, 14);
    tick();
    chk("drain_idle", out_valid, 0);

    // Same-cycle wake capture on port 1
    enq(5'd20, 8'h50, 4'h9, 5'd7, 1'b0, 5'd25, 1'b1);
    wake_valid = 2'b10;
    wake_tags  = {5'd7, 5'd0};
    sb.push_back(mk(5'd20, 8'h50, 4'h9, 5'd7, 5'd25));
    tick(); idle();
    wake_valid = 2'b00;
`ifdef TERM_IQ_BYPASS_EN
    chk("cap_valid", out_valid, 1);
    chk("cap_count", count, 0);
`else
    chk("cap_count", count, 1);
    tick();
    chk("cap_valid", out_valid, 1);
    chk("cap_count_after", count, 0);
`endif
    tick();
    chk("cap_idle", out_valid, 0);

    // Stall stability, then flush with a simultaneous enqueue
    out_ready = 1'b0;
    enq(5'd30, 8'h30, 4'h3, 5'd1, 1'b1, 5'd2, 1'b1);
    tick();
    enq(5'd31, 8'h31, 4'h3, 5'd1, 1'b1, 5'd2, 1'b1);
    tick(); idle();
    chk("stall_valid", out_valid, 1);
    chk("stall_count", count, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_rob", out_ROB_entry, 30);
      chk("stall_offset", out_offset, 8'h30);
    end
    flush = 1'b1;
    enq(5'd32, 8'h32, 4'h3, 5'd1, 1'b1, 5'd2, 1'b1);
    tick();
    flush = 1'b0;
    idle();
    chk("flush_valid", out_valid, 0);
    chk("flush_count", count, 0);
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_dropped_valid", out_valid, 0);
    chk("flush_dropped_count", count, 0);

    // Asynchronous reset with ops queued
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      enq(5'(40 + k), 8'(8'h60 + k), 4'h5, 5'd1, 1'b1, 5'd2, 1'b1);
      tick();
    end
    idle();
    chk("pre_rst_count", count, 3);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    tick(); tick();
    rst = 1'b0;

    // Clean operation after reset
    out_ready = 1'b1;
    enq(5'd17, 8'h55, 4'h6, 5'd9, 1'b1, 5'd10, 1'b1);
    sb.push_back(mk(5'd17, 8'h55, 4'h6, 5'd9, 5'd10));
    tick(); idle();
    tick(); tick(); tick();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
